// File: rtl/seg_addsub_pkg.sv
// Shared types and helpers for the segmented adder/subtractor.
// Saturation is enabled by defining SEG_ADDSUB_SAT_EN.
package seg_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seg_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
      return (seg_w == 0) ? 0 : width / seg_w;
   endfunction

endpackage

// File: rtl/seg_addsub_if.sv
// Operand/result handshake bundle for seg_addsub.
interface seg_addsub_if #(
   parameter int unsigned WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );

endinterface

// File: rtl/seg_add_slice.sv
// Combinational SEG_W-bit adder used once per cycle on the selected segment.
module seg_add_slice #(
   parameter int unsigned SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout
);

   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
   end

endmodule

// File: rtl/seg_addsub.sv
// Multi-cycle add/sub processing SEG_W bits per clock, LS segment first.
// Define SEG_ADDSUB_SAT_EN to saturate the result on signed overflow.
module seg_addsub
   import seg_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   seg_addsub_if.slave bus
);

   localparam int unsigned NSEG  = nseg(WIDTH, SEG_W);
   localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

   if (SEG_W < 1 || SEG_W > WIDTH || (WIDTH % SEG_W) != 0) begin : g_bad_width
      $error("seg_addsub: WIDTH must be a positive multiple of SEG_W");
   end

`ifdef SEG_ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;
`endif

   seg_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [31:0]      seg_lo;
   logic [SEG_W-1:0] seg_a, seg_b, seg_s;
   logic             seg_c;

   // One shared adder; the active segment is selected by idx_q.
   always_comb begin
      seg_lo = 32'(idx_q) * SEG_W;
      seg_a  = a_q[seg_lo +: SEG_W];
      seg_b  = b_q[seg_lo +: SEG_W];
   end

   seg_add_slice #(
      .SEG_W (SEG_W)
   ) u_slice (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (carry_q),
      .sum  (seg_s),
      .cout (seg_c)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d        = bus.a;
               b_d        = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
               carry_d    = bus.sub;
               sub_d      = bus.sub;
               idx_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end

         RUN: begin
            sum_d[seg_lo +: SEG_W] = seg_s;
            carry_d                = seg_c;
            if (idx_q == LAST_IDX) begin
               // Flags are taken from the fully assembled result on the DONE-entry edge.
               cout_d = seg_c ^ sub_q;
               ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SEG_ADDSUB_SAT_EN
               if (ovf_d) begin
                  sum_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
               end
`endif
               zero_d      = (sum_d == '0);
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seg_addsub.sv
// Directed self-checking bench for seg_addsub (32/8, 64/64 and 64/1 builds).
module tb_seg_addsub;
   import seg_addsub_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seg_addsub_if #(.WIDTH(32)) bus32 ();
   seg_addsub_if #(.WIDTH(64)) bus64w ();
   seg_addsub_if #(.WIDTH(64)) bus64n ();

   seg_addsub #(.WIDTH(32), .SEG_W(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   seg_addsub #(.WIDTH(64), .SEG_W(64)) u_dut64w (.clk(clk), .rst_n(rst_n), .bus(bus64w.slave));
   seg_addsub #(.WIDTH(64), .SEG_W(1)) u_dut64n (.clk(clk), .rst_n(rst_n), .bus(bus64n.slave));

`ifdef SEG_ADDSUB_SAT_EN
   localparam logic [31:0] T3A_SUM = 32'h7FFF_FFFF;
   localparam logic [31:0] T3B_SUM = 32'h8000_0000;
`else
   localparam logic [31:0] T3A_SUM = 32'h8000_0000;
   localparam logic [31:0] T3B_SUM = 32'h7FFF_FFFF;
`endif

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] s;
      logic        c;
      logic        v;
      logic        z;
   } vec64_t;

   vec64_t vt [6];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub, output int lat);
      int w = 0;
      while (!bus32.in_ready && w < 20) begin @(posedge clk); #1; w++; end
      bus32.a = a; bus32.b = b; bus32.sub = sub; bus32.in_valid = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0; bus32.a = ~a; bus32.b = ~b; bus32.sub = ~sub;
      lat = 0;
      while (!bus32.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic release32();
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus32.in_ready); end
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus32.out_valid); end
      checks++; if (bus32.sum !== 32'h0) begin errors++; $display("FAIL rst_sum got=%h exp=0", bus32.sum); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus32.cout, bus32.ovf, bus32.zero}); end
      checks++; if ({bus64w.in_ready, bus64n.in_ready} !== 2'b11) begin errors++; $display("FAIL rst_in_ready64 got=%b exp=11", {bus64w.in_ready, bus64n.in_ready}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_carry_wrap();
      int lat;
      run32(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency got=%0d exp=4", lat); end
      checks++; if (bus32.sum !== 32'h0) begin errors++; $display("FAIL t1_sum got=%h exp=00000000", bus32.sum); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b101) begin errors++; $display("FAIL t1_flags cov_z got=%b exp=101", {bus32.cout, bus32.ovf, bus32.zero}); end
      checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready got=%b exp=0", bus32.in_ready); end
      release32();
   endtask

   task automatic test_sub();
      int lat;
      run32(32'h0000_0005, 32'h0000_0007, OP_SUB, lat);
      checks++; if (bus32.sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL t2a_sum got=%h exp=fffffffe", bus32.sum); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b100) begin errors++; $display("FAIL t2a_flags got=%b exp=100", {bus32.cout, bus32.ovf, bus32.zero}); end
      release32();
      run32(32'h0000_0007, 32'h0000_0005, OP_SUB, lat);
      checks++; if (bus32.sum !== 32'h0000_0002) begin errors++; $display("FAIL t2b_sum got=%h exp=00000002", bus32.sum); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b000) begin errors++; $display("FAIL t2b_flags got=%b exp=000", {bus32.cout, bus32.ovf, bus32.zero}); end
      release32();
   endtask

   task automatic test_overflow();
      int lat;
      run32(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, lat);
      checks++; if (bus32.sum !== T3A_SUM) begin errors++; $display("FAIL t3a_sum got=%h exp=%h", bus32.sum, T3A_SUM); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b010) begin errors++; $display("FAIL t3a_flags got=%b exp=010", {bus32.cout, bus32.ovf, bus32.zero}); end
      release32();
      run32(32'h8000_0000, 32'h0000_0001, OP_SUB, lat);
      checks++; if (bus32.sum !== T3B_SUM) begin errors++; $display("FAIL t3b_sum got=%h exp=%h", bus32.sum, T3B_SUM); end
      checks++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b010) begin errors++; $display("FAIL t3b_flags got=%b exp=010", {bus32.cout, bus32.ovf, bus32.zero}); end
      release32();
   endtask

   task automatic test_backpressure();
      int lat;
      run32(32'h0000_1000, 32'h0000_0234, OP_ADD, lat);
      checks++; if (bus32.sum !== 32'h0000_1234) begin errors++; $display("FAIL t4_first_sum got=%h exp=00001234", bus32.sum); end
      bus32.a = 32'h1111_1111; bus32.b = 32'h2222_2222; bus32.sub = OP_ADD; bus32.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (bus32.sum !== 32'h0000_1234) begin errors++; $display("FAIL t4_hold_sum[%0d] got=%h exp=00001234", i, bus32.sum); end
         checks++; if ({bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.zero} !== 5'b10000) begin
            errors++; $display("FAIL t4_hold_ctl[%0d] got=%b exp=10000", i, {bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.zero});
         end
      end
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
      checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin errors++; $display("FAIL t4_release got=%b exp=01", {bus32.out_valid, bus32.in_ready}); end
      @(posedge clk); #1;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0;
      checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL t4_second_accept got=%b exp=0", bus32.in_ready); end
      lat = 0;
      while (!bus32.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL t4_second_latency got=%0d exp=4", lat); end
      checks++; if (bus32.sum !== 32'h3333_3333) begin errors++; $display("FAIL t4_second_sum got=%h exp=33333333", bus32.sum); end
      release32();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0123_4567; bus32.sub = OP_ADD; bus32.in_valid = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin errors++; $display("FAIL t5_in_reset got=%b exp=01", {bus32.out_valid, bus32.in_ready}); end
      checks++; if (bus32.sum !== 32'h0) begin errors++; $display("FAIL t5_sum_cleared got=%h exp=0", bus32.sum); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin errors++; $display("FAIL t5_after_release got=%b exp=01", {bus32.out_valid, bus32.in_ready}); end
      run32(32'h1234_5678, 32'h1111_1111, OP_ADD, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL t5_latency got=%0d exp=4", lat); end
      checks++; if (bus32.sum !== 32'h2345_6789) begin errors++; $display("FAIL t5_sum got=%h exp=23456789", bus32.sum); end
      release32();
   endtask

   task automatic test_wide();
      logic [63:0] es;
      int lw, ln, cyc;
      vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 64'h0, 1'b1, 1'b0, 1'b1};
      vt[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
      vt[2] = '{64'h0, 64'h1, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vt[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OP_SUB, 64'h0, 1'b0, 1'b0, 1'b1};
      vt[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, OP_ADD, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0};
      vt[5] = '{64'h8000_0000_0000_0000, 64'h1, OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         es = vt[i].s;
`ifdef SEG_ADDSUB_SAT_EN
         if (vt[i].v) es = vt[i].a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
         bus64w.a = vt[i].a; bus64w.b = vt[i].b; bus64w.sub = vt[i].sub; bus64w.in_valid = 1'b1;
         bus64n.a = vt[i].a; bus64n.b = vt[i].b; bus64n.sub = vt[i].sub; bus64n.in_valid = 1'b1;
         @(posedge clk); #1;
         bus64w.in_valid = 1'b0; bus64w.a = ~vt[i].a; bus64w.b = ~vt[i].b; bus64w.sub = ~vt[i].sub;
         bus64n.in_valid = 1'b0; bus64n.a = ~vt[i].a; bus64n.b = ~vt[i].b; bus64n.sub = ~vt[i].sub;
         lw = 0; ln = 0; cyc = 0;
         while ((lw == 0 || ln == 0) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (bus64w.out_valid && lw == 0) lw = cyc;
            if (bus64n.out_valid && ln == 0) ln = cyc;
         end
         checks++; if (lw !== 1) begin errors++; $display("FAIL t6w_latency[%0d] got=%0d exp=1", i, lw); end
         checks++; if (ln !== 64) begin errors++; $display("FAIL t6n_latency[%0d] got=%0d exp=64", i, ln); end
         checks++; if (bus64w.sum !== es) begin errors++; $display("FAIL t6w_sum[%0d] got=%h exp=%h", i, bus64w.sum, es); end
         checks++; if (bus64n.sum !== es) begin errors++; $display("FAIL t6n_sum[%0d] got=%h exp=%h", i, bus64n.sum, es); end
         checks++; if ({bus64w.cout, bus64w.ovf, bus64w.zero} !== {vt[i].c, vt[i].v, vt[i].z}) begin
            errors++; $display("FAIL t6w_flags[%0d] got=%b exp=%b", i, {bus64w.cout, bus64w.ovf, bus64w.zero}, {vt[i].c, vt[i].v, vt[i].z});
         end
         checks++; if ({bus64n.cout, bus64n.ovf, bus64n.zero} !== {vt[i].c, vt[i].v, vt[i].z}) begin
            errors++; $display("FAIL t6n_flags[%0d] got=%b exp=%b", i, {bus64n.cout, bus64n.ovf, bus64n.zero}, {vt[i].c, vt[i].v, vt[i].z});
         end
         bus64w.out_ready = 1'b1; bus64n.out_ready = 1'b1;
         @(posedge clk); #1;
         bus64w.out_ready = 1'b0; bus64n.out_ready = 1'b0;
      end
   endtask

   initial begin
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
      bus64w.in_valid = 1'b0; bus64w.a = '0; bus64w.b = '0; bus64w.sub = 1'b0; bus64w.out_ready = 1'b0;
      bus64n.in_valid = 1'b0; bus64n.a = '0; bus64n.b = '0; bus64n.sub = 1'b0; bus64n.out_ready = 1'b0;
      test_reset();
      test_carry_wrap();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_mid_run();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
